lif_param_loader: RTL and testbench

Upstream configuration stage for lif_neuron_dual_neuron. It receives a 5-byte parameter frame over a byte-wide pin interface with a slow, asynchronous strobe, and verifies an XOR checksum. Once verified, it commits weight_a, weight_b, leak_rate, threshold and leak_cycles atomically and asserts params_ready. The neuron keeps running on the old parameter set until a new frame commits.

---
 rtl/lif_pkg.sv | 31 +++
 rtl/lif_strobe_sync.sv | 26 ++
 rtl/lif_param_loader.sv | 160 ++++++++++++++++
 tb/tb_lif_param_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants for the LIF parameter loader and neuron: frame layout, FSM states, defaults.
package lif_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int IDX_W       = 0;
  localparam int IDX_LEAK    = 1;
  localparam int IDX_THR     = 2;
  localparam int IDX_LCYC    = 3;
  localparam int IDX_CSUM    = 4;

  // Field positions inside b0 and b3
  localparam int B0_WA_MSB = 7;
  localparam int B0_WA_LSB = 5;
  localparam int B0_WB_MSB = 4;
  localparam int B0_WB_LSB = 2;
  localparam int B3_LC_MSB = 3;
  localparam int B3_LC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } load_state_t;

  localparam logic [2:0] LIF_DEF_WEIGHT_A    = 3'd3;
  localparam logic [2:0] LIF_DEF_WEIGHT_B    = 3'd3;
  localparam logic [7:0] LIF_DEF_LEAK_RATE   = 8'd1;
  localparam logic [7:0] LIF_DEF_THRESHOLD   = 8'd64;
  localparam logic [3:0] LIF_DEF_LEAK_CYCLES = 4'd4;

endpackage

// File: rtl/lif_strobe_sync.sv
// Synchronizes the asynchronous byte strobe and emits a one-cycle pulse on its rising edge.
module lif_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_strobe,
  output logic o_byte_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_byte_evt = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/lif_param_loader.sv
// Receives a 5-byte XOR-checked parameter frame over a strobed byte interface and commits it atomically.
// The previous parameter set stays live through failed or aborted reloads.
module lif_param_loader
  import lif_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter logic [2:0] DEF_WEIGHT_A    = LIF_DEF_WEIGHT_A,
  parameter logic [2:0] DEF_WEIGHT_B    = LIF_DEF_WEIGHT_B,
  parameter logic [7:0] DEF_LEAK_RATE   = LIF_DEF_LEAK_RATE,
  parameter logic [7:0] DEF_THRESHOLD   = LIF_DEF_THRESHOLD,
  parameter logic [3:0] DEF_LEAK_CYCLES = LIF_DEF_LEAK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_mode,
  input  logic       load_strobe,
  input  logic [7:0] load_data,
  output logic [2:0] weight_a,
  output logic [2:0] weight_b,
  output logic [7:0] leak_rate,
  output logic [7:0] threshold,
  output logic [3:0] leak_cycles,
  output logic       params_ready,
  output logic       load_busy,
  output logic       load_error
);

  logic        w_byte_evt;
  load_state_t r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt, w_idx;
  logic [7:0]  r_xor, w_xor_nxt;
  logic        w_store, w_commit, w_set_err, w_clr_err;

  logic [2:0]  r_sh_wa, r_sh_wb, r_wa, r_wb;
  logic [7:0]  r_sh_leak, r_sh_thr, r_leak, r_thr;
  logic [3:0]  r_sh_lc, r_lc;
  logic        r_ready, r_err;

  lif_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_strobe  (load_strobe),
    .o_byte_evt(w_byte_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_xor   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xor   <= w_xor_nxt;
    end
  end

  // Abort on load_mode low takes priority over a coincident byte in RECV
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_xor_nxt   = r_xor;
    w_idx       = r_cnt;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_byte_evt && load_mode) begin
          w_idx       = 3'(IDX_W);
          w_store     = 1'b1;
          w_xor_nxt   = load_data;
          w_cnt_nxt   = 3'd1;
          w_clr_err   = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (!load_mode) begin
          w_cnt_nxt   = '0;
          w_xor_nxt   = '0;
          w_set_err   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_byte_evt) begin
          w_store   = 1'b1;
          w_xor_nxt = r_xor ^ load_data;
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'(IDX_CSUM)) w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_commit    = (r_xor == 8'h00);
        w_set_err   = (r_xor != 8'h00);
        w_cnt_nxt   = '0;
        w_xor_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_xor_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_wa   <= DEF_WEIGHT_A;
      r_sh_wb   <= DEF_WEIGHT_B;
      r_sh_leak <= DEF_LEAK_RATE;
      r_sh_thr  <= DEF_THRESHOLD;
      r_sh_lc   <= DEF_LEAK_CYCLES;
    end else if (w_store) begin
      case (w_idx)
        3'(IDX_W): begin
          r_sh_wa <= load_data[B0_WA_MSB:B0_WA_LSB];
          r_sh_wb <= load_data[B0_WB_MSB:B0_WB_LSB];
        end
        3'(IDX_LEAK): r_sh_leak <= load_data;
        3'(IDX_THR):  r_sh_thr  <= load_data;
        3'(IDX_LCYC): r_sh_lc   <= load_data[B3_LC_MSB:B3_LC_LSB];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wa    <= DEF_WEIGHT_A;
      r_wb    <= DEF_WEIGHT_B;
      r_leak  <= DEF_LEAK_RATE;
      r_thr   <= DEF_THRESHOLD;
      r_lc    <= DEF_LEAK_CYCLES;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wa    <= r_sh_wa;
        r_wb    <= r_sh_wb;
        r_leak  <= r_sh_leak;
        r_thr   <= r_sh_thr;
        r_lc    <= r_sh_lc;
        r_ready <= 1'b1;
      end
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
    end
  end

  assign weight_a     = r_wa;
  assign weight_b     = r_wb;
  assign leak_rate    = r_leak;
  assign threshold    = r_thr;
  assign leak_cycles  = r_lc;
  assign params_ready = r_ready;
  assign load_error   = r_err;
  assign load_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_lif_param_loader.sv
// Directed bench for lif_param_loader: hand-computed frames, commit latency, error and abort paths.
module tb_lif_param_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_mode;
  logic       load_strobe;
  logic [7:0] load_data;
  logic [2:0] weight_a, weight_b;
  logic [7:0] leak_rate, threshold;
  logic [3:0] leak_cycles;
  logic       params_ready, load_busy, load_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lif_param_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_mode   (load_mode),
    .load_strobe (load_strobe),
    .load_data   (load_data),
    .weight_a    (weight_a),
    .weight_b    (weight_b),
    .leak_rate   (leak_rate),
    .threshold   (threshold),
    .leak_cycles (leak_cycles),
    .params_ready(params_ready),
    .load_busy   (load_busy),
    .load_error  (load_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_params(input string tag, input int wa, input int wb, input int lr,
                              input int th, input int lc);
    check({tag, ".wa"}, 32'(weight_a), 32'(wa));
    check({tag, ".wb"}, 32'(weight_b), 32'(wb));
    check({tag, ".leak"}, 32'(leak_rate), 32'(lr));
    check({tag, ".thr"}, 32'(threshold), 32'(th));
    check({tag, ".lcyc"}, 32'(leak_cycles), 32'(lc));
  endtask

  task automatic check_flags(input string tag, input logic rdy, input logic busy, input logic err);
    check({tag, ".ready"}, 32'(params_ready), 32'(rdy));
    check({tag, ".busy"}, 32'(load_busy), 32'(busy));
    check({tag, ".err"}, 32'(load_error), 32'(err));
  endtask

  // One strobe: raise just after an edge, hold for 'hold' cycles, then idle gap
  task automatic send_byte(input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    load_data   = d;
    load_strobe = 1'b1;
    repeat (hold) @(posedge clk);
    #1 load_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input int hold);
    send_byte(b0, hold);
    send_byte(b1, hold);
    send_byte(b2, hold);
    send_byte(b3, hold);
    send_byte(b4, hold);
  endtask

  initial begin
    reset       = 1'b1;
    load_mode   = 1'b0;
    load_strobe = 1'b0;
    load_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check_params("rst", 3, 3, 1, 64, 4);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    // Strobes with load_mode low are ignored
    send_frame(8'h6C, 8'h02, 8'h40, 8'h05, 8'h2B, 4);
    check_params("nomode", 3, 3, 1, 64, 4);
    check_flags("nomode", 1'b0, 1'b0, 1'b0);

    // Valid frame with edge-accurate commit latency on the last byte
    load_mode = 1'b1;
    send_byte(8'h6C, 4);
    check("first.busy", 32'(load_busy), 32'd1);
    send_byte(8'h02, 4);
    send_byte(8'h40, 4);
    send_byte(8'h05, 4);
    @(posedge clk); #1;
    load_data   = 8'h2B;
    load_strobe = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("lat.evt_cycle.ready", 32'(params_ready), 32'd0);
    @(posedge clk); #1;
    check("lat.check_cycle.ready", 32'(params_ready), 32'd0);
    check("lat.check_cycle.busy", 32'(load_busy), 32'd1);
    check("lat.check_cycle.leak", 32'(leak_rate), 32'd1);
    @(posedge clk); #1;
    check_flags("good1", 1'b1, 1'b0, 1'b0);
    check_params("good1", 3, 3, 2, 64, 5);
    load_strobe = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Bad checksums keep the old set and flag an error
    send_frame(8'h6C, 8'h02, 8'h40, 8'h05, 8'h2A, 4);
    check_flags("bad1", 1'b1, 1'b0, 1'b1);
    check_params("bad1", 3, 3, 2, 64, 5);
    send_frame(8'hE4, 8'h01, 8'h20, 8'h03, 8'h00, 4);
    check_flags("bad2", 1'b1, 1'b0, 1'b1);
    check_params("bad2", 3, 3, 2, 64, 5);

    // Abort after three bytes; first byte of a frame clears the sticky error
    send_byte(8'hE4, 4);
    check("abort.b0_clears_err", 32'(load_error), 32'd0);
    send_byte(8'h01, 4);
    send_byte(8'h20, 4);
    check("abort.busy_before", 32'(load_busy), 32'd1);
    load_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_flags("abort", 1'b1, 1'b0, 1'b1);
    check_params("abort", 3, 3, 2, 64, 5);
    load_mode = 1'b1;
    send_frame(8'hE4, 8'h01, 8'h20, 8'h03, 8'hC6, 4);
    check_flags("good2", 1'b1, 1'b0, 1'b0);
    check_params("good2", 7, 1, 1, 32, 3);

    // Reset mid-frame; later strobes begin a fresh frame at b0
    send_byte(8'h6C, 4);
    send_byte(8'h02, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_params("midrst", 3, 3, 1, 64, 4);
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    send_byte(8'h40, 4);
    send_byte(8'h05, 4);
    send_byte(8'h2B, 4);
    check_flags("midrst.partial", 1'b0, 1'b1, 1'b0);
    send_byte(8'h07, 4);
    send_byte(8'h69, 4);
    check_flags("midrst.done", 1'b1, 1'b0, 1'b0);
    check_params("midrst.done", 2, 0, 5, 43, 7);

    // Long strobe pulses must each deliver exactly one byte
    send_frame(8'h6C, 8'h02, 8'h40, 8'h05, 8'h2B, 20);
    check_flags("longstb", 1'b1, 1'b0, 1'b0);
    check_params("longstb", 3, 3, 2, 64, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
